// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, sitting on the MEM-stage data bus.
// TXD at BASE_ADDR pushes a byte; STATUS at BASE_ADDR+4 reports count/overflow/empty/full/busy.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for one bit time
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); chains straight into the next START when bytes are queued
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h4000_0018,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] Read_data,
   output logic        tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH      = (AW+1)'(FIFO_DEPTH);
   localparam logic [31:0]   STAT_ADDR  = BASE_ADDR + 32'd4;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_n;
   logic [BW-1:0]   baud, baud_n;
   logic [2:0]      bit_idx, bit_idx_n;
   logic [7:0]      shift, shift_n;
   logic            tx_n;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            overflow;

   logic txd_hit, stat_hit, wr_req, stat_rd;
   logic fifo_empty, fifo_full, push, drop, pop, busy;
   logic [31:0] status;

   assign txd_hit    = (Address[31:2] == BASE_ADDR[31:2]);
   assign stat_hit   = (Address[31:2] == STAT_ADDR[31:2]);
   assign wr_req     = MemWrite & txd_hit;
   assign stat_rd    = MemRead & stat_hit;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == DEPTH);
   // Full check uses the pre-edge count, so a same-cycle pop never frees room for the push.
   assign push       = wr_req & ~fifo_full;
   assign drop       = wr_req & fifo_full;
   assign busy       = (state != IDLE);
   assign status     = {16'b0, 8'(count), 4'b0, overflow, fifo_empty, fifo_full, busy};

   always_comb begin
      state_n   = state;
      baud_n    = baud;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = mem[rd_ptr];
               baud_n  = '0;
               state_n = START;
            end
         end
         START: begin
            if (baud == BAUD_LAST) begin
               baud_n    = '0;
               bit_idx_n = 3'd0;
               state_n   = DATA;
            end else begin
               baud_n = baud + BW'(1);
            end
         end
         DATA: begin
            if (baud == BAUD_LAST) begin
               baud_n  = '0;
               shift_n = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_idx_n = bit_idx + 3'd1;
            end else begin
               baud_n = baud + BW'(1);
            end
         end
         STOP: begin
            if (baud == BAUD_LAST) begin
               baud_n = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_n = mem[rd_ptr];
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_n = baud + BW'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         tx      <= tx_n;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= Write_data[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         Read_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         // A dropped push wins over the clear-on-read.
         if (drop)         overflow <= 1'b1;
         else if (stat_rd) overflow <= 1'b0;
         Read_data <= stat_rd ? status : 32'b0;
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with a 4-clock bit time; frames checked sample by sample.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h4000_0018;
   localparam logic [31:0] STAT = 32'h4000_001C;
   localparam int          CPB  = 4;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] Read_data;
   logic        tx;

   int vectors;
   int miscompares;

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .Address    (Address),
      .Write_data (Write_data),
      .MemWrite   (MemWrite),
      .MemRead    (MemRead),
      .Read_data  (Read_data),
      .tx         (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Called at sample index 'skip' of a frame (sample 0 = just after the edge where tx falls).
   task automatic check_frame(input logic [7:0] b, input int skip, input string tag);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int k = skip; k < 10*CPB; k++) begin
         chk(tag, {31'b0, tx}, {31'b0, f[k/CPB]});
         tick();
      end
   endtask

   task automatic stat_read(input logic [31:0] addr, input logic [31:0] expv, input string tag);
      Address = addr;
      MemRead = 1'b1;
      tick();
      MemRead = 1'b0;
      chk(tag, Read_data, expv);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      Address     = '0;
      Write_data  = '0;
      MemWrite    = 1'b0;
      MemRead     = 1'b0;

      #23;
      chk("rst_tx", {31'b0, tx}, 32'd1);
      chk("rst_rd", Read_data, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      stat_read(STAT, 32'h0000_0004, "rst_stat");

      // Single byte 0x55 written at edge 0; tx falls after edge 1
      Address = BASE; Write_data = 32'hFFFF_FF55; MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0;
      chk("t1_idle_after_push", {31'b0, tx}, 32'd1);
      tick();
      check_frame(8'h55, 0, "t1_frame");
      chk("t1_tx_idle", {31'b0, tx}, 32'd1);
      stat_read(STAT, 32'h0000_0004, "t1_stat");

      // Status one edge after a write, then once the byte has been popped
      Address = BASE; Write_data = 32'h0000_00A5; MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0;
      Address = STAT; MemRead = 1'b1;
      tick();
      chk("t3_stat_queued", Read_data, 32'h0000_0100);
      tick();
      MemRead = 1'b0;
      chk("t3_stat_busy", Read_data, 32'h0000_0005);
      check_frame(8'hA5, 1, "t3_frame");

      // Ten back-to-back writes: one byte goes in flight at edge 1, eight queue, the tenth drops
      for (int i = 0; i < 10; i++) begin
         Address = BASE; Write_data = 32'h30 + i; MemWrite = 1'b1;
         tick();
      end
      MemWrite = 1'b0;
      stat_read(STAT, 32'h0000_080B, "t2_stat_ovf");
      check_frame(8'h30, 9, "t2_frame0");
      for (int i = 1; i < 9; i++) check_frame(8'(8'h30 + i), 0, "t2_frame");
      chk("t2_no_tenth", {31'b0, tx}, 32'd1);
      stat_read(STAT, 32'h0000_0004, "t2_stat_cleared");

      // Fill to 8 queued, then push on the STOP-end pop edge (edge 41)
      for (int i = 0; i < 9; i++) begin
         Address = BASE; Write_data = 32'h0000_0000; MemWrite = 1'b1;
         tick();
      end
      MemWrite = 1'b0;
      repeat (31) tick();
      stat_read(STAT, 32'h0000_0803, "t4_stat_full");
      Address = BASE; Write_data = 32'h0000_0077; MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0;
      chk("t4_next_start", {31'b0, tx}, 32'd0);
      stat_read(STAT, 32'h0000_0709, "t4_stat_drop");

      // Reset asserted mid-DATA of a zero byte
      repeat (10) tick();
      chk("t5_pre_rst_tx", {31'b0, tx}, 32'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("t5_async_tx", {31'b0, tx}, 32'd1);
      tick();
      reset = 1'b1;
      tick();
      stat_read(STAT, 32'h0000_0004, "t5_stat");
      for (int i = 0; i < 45; i++) begin
         chk("t5_no_residual", {31'b0, tx}, 32'd1);
         tick();
      end

      // Non-hit write/read, STAT with low address bits set, TXD read
      Address = BASE + 32'd8; Write_data = 32'h0000_0041; MemWrite = 1'b1; MemRead = 1'b1;
      tick();
      MemWrite = 1'b0; MemRead = 1'b0;
      chk("t6_nonhit_rd", Read_data, 32'd0);
      stat_read(STAT + 32'd3, 32'h0000_0004, "t6_stat_lowbits");
      stat_read(BASE, 32'h0000_0000, "t6_txd_rd");
      for (int i = 0; i < 6; i++) begin
         chk("t6_tx_idle", {31'b0, tx}, 32'd1);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
